// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the boot-time program loader.
//   state_e     - loader FSM states
//   LEN_BYTES   - header length field size in bytes
//   WORD_BYTES  - bytes per instruction word
//   is_loading  - true in states where the loader accepts stream bytes
package prog_loader_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LEN_W      = BYTE_W * LEN_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  function automatic logic is_loading(input state_e s);
    return s inside {ST_HDR_HI, ST_HDR_LO, ST_PAYLOAD, ST_CHECK};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Bus interfaces for prog_loader.
//   prog_loader_if     - byte stream: in_data/in_valid from source, in_ready back.
//                        master = stream source, slave = loader.
//   prog_loader_mem_if - instruction-memory write port: mem_wr_en/addr/data.
//                        master = loader, slave = memory.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

interface prog_loader_mem_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  import prog_loader_pkg::*;

  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [WORD_W-1:0]     mem_wr_data;

  modport master (output mem_wr_en, output mem_wr_addr, output mem_wr_data);
  modport slave  (input mem_wr_en, input mem_wr_addr, input mem_wr_data);
endinterface

// File: rtl/prog_loader_word_assembler.sv
// word_assembler: shifts stream bytes MSB-first into a 32-bit word, counts
// bytes within the word and keeps a running XOR checksum of every byte.
//   i_clk, i_rst_n - clock, async active-low reset
//   i_clear        - synchronous clear of counter, shift register, checksum
//   i_advance      - accept i_byte this cycle
//   i_byte         - stream byte
//   o_word         - word formed by the stored bytes plus i_byte (valid with o_word_ready)
//   o_word_ready   - i_byte is the last byte of the current word
//   o_csum         - XOR of all bytes advanced since the last clear
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_advance,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_ready,
  output logic [BYTE_W-1:0] o_csum
);

  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

  // Only the three leading bytes need storage; the fourth arrives on i_byte.
  logic [WORD_W-BYTE_W-1:0] r_shift;
  logic [1:0]               r_cnt;
  logic [BYTE_W-1:0]        r_csum;

  assign o_word       = {r_shift, i_byte};
  assign o_word_ready = i_advance && (r_cnt == LAST_BYTE);
  assign o_csum       = r_csum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
    end else if (i_advance) begin
      r_shift <= o_word[WORD_W-BYTE_W-1:0];
      r_cnt   <= r_cnt + 2'd1;
      r_csum  <= r_csum ^ i_byte;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot-time loader for the multicycle CPU. Receives a framed byte
// stream (2-byte big-endian word count N, 4N payload bytes MSB-first, XOR
// checksum byte), writes assembled words to instruction memory and releases
// the CPU from reset only once the whole image is written and verified.
//   clk, reset - system clock, async active-low reset
//   start      - one-cycle pulse; starts a load from IDLE, DONE or ERROR
//   strm       - byte stream (slave): in_data, in_valid, in_ready
//   mem        - instruction-memory write port (master): mem_wr_en/addr/data
//   cpu_reset  - active-high CPU reset, low only in DONE
//   done       - image loaded and checksum matched
//   error      - checksum mismatch or oversize header
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  prog_loader_if.slave      strm,
  prog_loader_mem_if.master mem,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int unsigned CAPACITY = 32'd1 << ADDR_WIDTH;

  state_e                r_state, w_state_next;
  logic [LEN_W-1:0]      r_len, w_len_next;
  // One extra bit so a full-capacity image can count past the last address.
  logic [ADDR_WIDTH:0]   r_widx, w_widx_next;
  logic [ADDR_WIDTH-1:0] r_mem_wr_addr, w_mem_wr_addr_next;
  logic [WORD_W-1:0]     r_mem_wr_data, w_mem_wr_data_next;
  logic                  r_in_ready;
  logic                  r_mem_wr_en;
  logic                  r_done;
  logic                  r_error;
  logic                  r_cpu_reset;

  logic                  w_accept;
  logic                  w_restart;
  logic                  w_advance;
  logic                  w_word_ready;
  logic [WORD_W-1:0]     w_word;
  logic [BYTE_W-1:0]     w_csum;
  logic [LEN_W-1:0]      w_hdr_len;
  logic [ADDR_WIDTH:0]   w_widx_inc;

  assign w_accept   = strm.in_valid && r_in_ready;
  assign w_restart  = start && (r_state inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign w_advance  = w_accept && (r_state == ST_PAYLOAD);
  assign w_hdr_len  = {r_len[LEN_W-1:BYTE_W], strm.in_data};
  assign w_widx_inc = r_widx + (ADDR_WIDTH+1)'(1);

  word_assembler u_asm (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_clear      (w_restart),
    .i_advance    (w_advance),
    .i_byte       (strm.in_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready),
    .o_csum       (w_csum)
  );

  always_comb begin
    w_state_next       = r_state;
    w_len_next         = r_len;
    w_widx_next        = r_widx;
    w_mem_wr_addr_next = r_mem_wr_addr;
    w_mem_wr_data_next = r_mem_wr_data;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          w_state_next = ST_HDR_HI;
          w_widx_next  = '0;
        end
      end
      ST_HDR_HI: begin
        if (w_accept) begin
          w_len_next   = {strm.in_data, r_len[BYTE_W-1:0]};
          w_state_next = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (w_accept) begin
          w_len_next = w_hdr_len;
          if (32'(w_hdr_len) > CAPACITY) begin
            w_state_next = ST_ERROR;
          end else if (w_hdr_len == '0) begin
            w_state_next = ST_CHECK;
          end else begin
            w_state_next = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_word_ready) begin
          w_mem_wr_addr_next = r_widx[ADDR_WIDTH-1:0];
          w_mem_wr_data_next = w_word;
          w_widx_next        = w_widx_inc;
          if (32'(w_widx_inc) == 32'(r_len)) begin
            w_state_next = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (w_accept) begin
          w_state_next = (strm.in_data == w_csum) ? ST_DONE : ST_ERROR;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one appears in the
  // cycle after the edge that caused the transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_len         <= '0;
      r_widx        <= '0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
      r_in_ready    <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_cpu_reset   <= 1'b1;
    end else begin
      r_state       <= w_state_next;
      r_len         <= w_len_next;
      r_widx        <= w_widx_next;
      r_mem_wr_addr <= w_mem_wr_addr_next;
      r_mem_wr_data <= w_mem_wr_data_next;
      r_in_ready    <= is_loading(w_state_next);
      r_mem_wr_en   <= w_word_ready;
      r_done        <= (w_state_next == ST_DONE);
      r_error       <= (w_state_next == ST_ERROR);
      r_cpu_reset   <= (w_state_next != ST_DONE);
    end
  end

  assign strm.in_ready   = r_in_ready;
  assign mem.mem_wr_en   = r_mem_wr_en;
  assign mem.mem_wr_addr = r_mem_wr_addr;
  assign mem.mem_wr_data = r_mem_wr_data;
  assign cpu_reset       = r_cpu_reset;
  assign done            = r_done;
  assign error           = r_error;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int unsigned AW = 2;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  typedef struct packed {
    logic done;
    logic error;
    logic cpu_reset;
  } st_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic cpu_reset, done, error;

  prog_loader_if strm();
  prog_loader_mem_if #(.ADDR_WIDTH(AW)) mem();

  prog_loader #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .strm      (strm),
    .mem       (mem),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  wr_t exp_wr[$];
  st_t exp_st[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  localparam st_t ST_OK  = '{done: 1'b1, error: 1'b0, cpu_reset: 1'b0};
  localparam st_t ST_BAD = '{done: 1'b0, error: 1'b1, cpu_reset: 1'b1};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // All stimulus tasks are entered and left just after a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    strm.in_data  = b;
    strm.in_valid = 1'b1;
    while (!strm.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("in_ready_wait", 32'(strm.in_ready), 32'd1);
    @(negedge clk);
    strm.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Pushes the expected memory writes, then streams header, payload, checksum.
  // With gappy set, idle cycles and an ignored start pulse are interleaved.
  task automatic send_frame(input logic [15:0] n, input bq_t pl, input logic [7:0] ck,
                            input bit gappy);
    wr_t e;
    for (int unsigned w = 0; w < pl.size() / 4; w++) begin
      e.addr = w[AW-1:0];
      e.data = {pl[4*w], pl[4*w+1], pl[4*w+2], pl[4*w+3]};
      exp_wr.push_back(e);
    end
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int unsigned i = 0; i < pl.size(); i++) begin
      send_byte(pl[i]);
      if (gappy) begin
        repeat (i % 3) @(negedge clk);
        if (i == 5) pulse_start();
      end
    end
    send_byte(ck);
  endtask

  task automatic drain_writes(input string name);
    int unsigned n = 0;
    while (exp_wr.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_wr.size()), 32'd0);
  endtask

  task automatic check_status(input string name, input st_t e);
    check(name, {29'd0, done, error, cpu_reset}, {29'd0, e});
  endtask

  // Monitor: pops expected writes on every strobe, expected status on every
  // rising edge of done or error.
  initial begin
    st_t s;
    wr_t w;
    forever begin
      @(negedge clk);
      if (mem.mem_wr_en) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 32'(mem.mem_wr_en), 32'd0);
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", 32'(mem.mem_wr_addr), 32'(w.addr));
          check("wr_data", mem.mem_wr_data, w.data);
        end
      end
      if ((done && !prev_done) || (error && !prev_err)) begin
        if (exp_st.size() == 0) begin
          check("unexpected_status", {30'd0, done, error}, 32'd0);
        end else begin
          s = exp_st.pop_front();
          check("status", {29'd0, done, error, cpu_reset}, {29'd0, s});
          check("writes_before_status", 32'(exp_wr.size()), 32'd0);
        end
      end
      prev_done = done;
      prev_err  = error;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bq_t frame_a;
    bq_t frame_full;
    bq_t empty_q;
    frame_a    = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
    frame_full = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                   8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h01};
    strm.in_data  = 8'h00;
    strm.in_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(strm.in_ready), 32'd0);
    check("rst_wr_en", 32'(mem.mem_wr_en), 32'd0);
    check("rst_wr_addr", 32'(mem.mem_wr_addr), 32'd0);
    check("rst_wr_data", mem.mem_wr_data, 32'd0);
    check_status("rst_status", '{done: 1'b0, error: 1'b0, cpu_reset: 1'b1});
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_in_ready", 32'(strm.in_ready), 32'd0);

    // Two-word image; payload XOR is 0x21.
    exp_st.push_back(ST_OK);
    pulse_start();
    check("hdr_in_ready", 32'(strm.in_ready), 32'd1);
    send_frame(16'd2, frame_a, 8'h21, 1'b0);
    check_status("a_done", ST_OK);
    drain_writes("a_drain");

    // Restart from DONE re-asserts cpu_reset on the start edge.
    pulse_start();
    check_status("restart_status", '{done: 1'b0, error: 1'b0, cpu_reset: 1'b1});
    exp_st.push_back(ST_BAD);
    send_frame(16'd2, frame_a, 8'h28, 1'b0);
    check_status("bad_ck", ST_BAD);
    check("bad_ck_in_ready", 32'(strm.in_ready), 32'd0);
    drain_writes("bad_ck_drain");

    exp_st.push_back(ST_OK);
    pulse_start();
    send_frame(16'd2, frame_a, 8'h21, 1'b0);
    check_status("recover_done", ST_OK);
    drain_writes("recover_drain");

    // Oversize header: 5 words into a 4-word memory.
    exp_st.push_back(ST_BAD);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h05);
    check_status("oversize", ST_BAD);
    check("oversize_in_ready", 32'(strm.in_ready), 32'd0);
    strm.in_data  = 8'hA5;
    strm.in_valid = 1'b1;
    repeat (4) @(negedge clk);
    strm.in_valid = 1'b0;
    check("oversize_hold", {30'd0, error, strm.in_ready}, 32'd2);

    // Full-capacity image, last word at address 3; XOR is 0x01.
    exp_st.push_back(ST_OK);
    pulse_start();
    send_frame(16'd4, frame_full, 8'h01, 1'b0);
    check_status("full_done", ST_OK);
    drain_writes("full_drain");

    // Empty image.
    exp_st.push_back(ST_OK);
    pulse_start();
    send_frame(16'd0, empty_q, 8'h00, 1'b0);
    check_status("zero_done", ST_OK);
    exp_st.push_back(ST_BAD);
    pulse_start();
    send_frame(16'd0, empty_q, 8'h01, 1'b0);
    check_status("zero_err", ST_BAD);

    // Gaps and an ignored start mid-payload.
    exp_st.push_back(ST_OK);
    pulse_start();
    send_frame(16'd2, frame_a, 8'h21, 1'b1);
    check_status("gap_done", ST_OK);
    drain_writes("gap_drain");

    // Reset mid-word.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h24);
    send_byte(8'h08);
    #2 reset = 1'b0;
    #1;
    check("midrst_in_ready", 32'(strm.in_ready), 32'd0);
    check("midrst_wr_en", 32'(mem.mem_wr_en), 32'd0);
    check("midrst_wr_addr", 32'(mem.mem_wr_addr), 32'd0);
    check("midrst_wr_data", mem.mem_wr_data, 32'd0);
    check_status("midrst_status", '{done: 1'b0, error: 1'b0, cpu_reset: 1'b1});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(strm.in_ready), 32'd0);
    exp_st.push_back(ST_OK);
    pulse_start();
    send_frame(16'd2, frame_a, 8'h21, 1'b0);
    check_status("post_rst_done", ST_OK);
    drain_writes("post_rst_drain");

    repeat (5) @(negedge clk);
    check("status_queue_empty", 32'(exp_st.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
